// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants, stage payload type and width helper for
//                the elastic inter-stage pipeline registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int DATAPATH_WIDTH = 64;
    localparam int REGFILE_ADDR   = 3;
    localparam int DEFAULT_OPS    = 2;

    // Payload for the default configuration; wider or narrower instances
    // carry the same field order as a flat vector.
    typedef struct packed {
        logic                                  wreg_en;
        logic                                  wmem_en;
        logic [DEFAULT_OPS*DATAPATH_WIDTH-1:0] ops;
        logic [REGFILE_ADDR-1:0]               wreg;
    } stage_payload_t;

    // Flat payload width: two enables, the operand words, the register address.
    function automatic int payload_width(input int num_ops, input int data_w,
                                         input int addr_w);
        return 2 + num_ops * data_w + addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_entry.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_entry
//  Description : One payload register with its valid bit. Clear drops the
//                valid bit but keeps the data; clear wins over load.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int WIDTH = payload_width(DEFAULT_OPS, DATAPATH_WIDTH, REGFILE_ADDR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Entry storage: reset zeroes everything, clear only invalidates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= d;
            r_valid <= 1'b1;
        end
    end

    assign q     = r_data;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Elastic pipeline register with a two-entry skid buffer,
//                registered in_ready, flush and saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH      = DATAPATH_WIDTH,
    parameter int NUM_OPS         = DEFAULT_OPS,
    parameter int REG_ADDR_WIDTH  = REGFILE_ADDR,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_wreg_en,
    input  logic                          in_wmem_en,
    input  logic [NUM_OPS*DATA_WIDTH-1:0] in_ops,
    input  logic [REG_ADDR_WIDTH-1:0]     in_wreg,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_wreg_en,
    output logic                          out_wmem_en,
    output logic [NUM_OPS*DATA_WIDTH-1:0] out_ops,
    output logic [REG_ADDR_WIDTH-1:0]     out_wreg,
    output logic [STALL_CNT_WIDTH-1:0]    stall_cnt
);

    localparam int c_OPS_W     = NUM_OPS * DATA_WIDTH;
    localparam int c_PAYLOAD_W = payload_width(NUM_OPS, DATA_WIDTH, REG_ADDR_WIDTH);

    logic [c_PAYLOAD_W-1:0]     w_in_payload;
    logic [c_PAYLOAD_W-1:0]     w_main_d;
    logic [c_PAYLOAD_W-1:0]     w_main_q;
    logic [c_PAYLOAD_W-1:0]     w_skid_q;
    logic                       w_main_valid;
    logic                       w_skid_valid;
    logic                       w_accept;
    logic                       w_xfer;
    logic                       w_load_main;
    logic                       w_clear_main;
    logic                       w_load_skid;
    logic                       w_clear_skid;
    logic                       w_skid_valid_nxt;
    logic                       r_in_ready;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    assign w_in_payload = {in_wreg_en, in_wmem_en, in_ops, in_wreg};

    assign w_accept = in_valid & r_in_ready;
    assign w_xfer   = w_main_valid & out_ready;

    // Main refills from skid when skid holds the older entry, otherwise from
    // the input when main is empty or draining this cycle.
    assign w_load_main  = !flush & ((w_skid_valid & w_xfer) |
                          (!w_skid_valid & w_accept & (!w_main_valid | w_xfer)));
    assign w_clear_main = flush | (w_xfer & !w_load_main);
    assign w_main_d     = w_skid_valid ? w_skid_q : w_in_payload;

    // Skid only catches an accept that main cannot take.
    assign w_load_skid  = !flush & w_accept & w_main_valid & !w_xfer;
    assign w_clear_skid = flush | (w_skid_valid & w_xfer);

    assign w_skid_valid_nxt = !flush & (w_load_skid | (w_skid_valid & !w_xfer));

    pipe_skid_entry #(.WIDTH(c_PAYLOAD_W)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (w_load_main),
        .clear (w_clear_main),
        .d     (w_main_d),
        .q     (w_main_q),
        .valid (w_main_valid)
    );

    pipe_skid_entry #(.WIDTH(c_PAYLOAD_W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (w_load_skid),
        .clear (w_clear_skid),
        .d     (w_in_payload),
        .q     (w_skid_q),
        .valid (w_skid_valid)
    );

    // in_ready mirrors the next skid state so it never depends on out_ready
    // combinationally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= !w_skid_valid_nxt;
        end
    end

    // Saturating count of cycles where the output is held by backpressure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = w_main_valid;
    assign out_wreg_en = w_main_q[c_PAYLOAD_W-1] & w_main_valid;
    assign out_wmem_en = w_main_q[c_PAYLOAD_W-2] & w_main_valid;
    assign out_ops     = w_main_q[REG_ADDR_WIDTH +: c_OPS_W];
    assign out_wreg    = w_main_q[REG_ADDR_WIDTH-1:0];
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Self-checking bench for pipe_stage_skid; default instance is
//                compared with a queue model, a second narrow instance covers
//                counter saturation and a three-operand payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    typedef struct packed {
        logic         wreg_en;
        logic         wmem_en;
        logic [127:0] ops;
        logic [2:0]   wreg;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready, in_wreg_en, in_wmem_en;
    logic [127:0] in_ops;
    logic [2:0]   in_wreg;
    logic         out_valid, out_ready, out_wreg_en, out_wmem_en;
    logic [127:0] out_ops;
    logic [2:0]   out_wreg;
    logic [15:0]  stall_cnt;

    logic         b_reset, b_flush, b_in_valid, b_in_ready, b_in_wreg_en, b_in_wmem_en;
    logic [95:0]  b_in_ops;
    logic [2:0]   b_in_wreg;
    logic         b_out_valid, b_out_ready, b_out_wreg_en, b_out_wmem_en;
    logic [95:0]  b_out_ops;
    logic [2:0]   b_out_wreg;
    logic [3:0]   b_stall_cnt;

    ent_t         m_q[$];
    int unsigned  m_stall;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_wreg_en(in_wreg_en), .in_wmem_en(in_wmem_en), .in_ops(in_ops), .in_wreg(in_wreg),
        .out_valid(out_valid), .out_ready(out_ready), .out_wreg_en(out_wreg_en),
        .out_wmem_en(out_wmem_en), .out_ops(out_ops), .out_wreg(out_wreg), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.DATA_WIDTH(32), .NUM_OPS(3), .REG_ADDR_WIDTH(3), .STALL_CNT_WIDTH(4)) dut2 (
        .clk(clk), .reset(b_reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_wreg_en(b_in_wreg_en), .in_wmem_en(b_in_wmem_en), .in_ops(b_in_ops), .in_wreg(b_in_wreg),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_wreg_en(b_out_wreg_en),
        .out_wmem_en(b_out_wmem_en), .out_ops(b_out_ops), .out_wreg(b_out_wreg), .stall_cnt(b_stall_cnt)
    );

    // Reference behaviour: a FIFO of capacity two whose head is the output.
    task automatic step();
        bit   acc, xf, stl;
        ent_t e;
        acc = in_valid && (m_q.size() < 2);
        xf  = (m_q.size() > 0) && out_ready;
        stl = (m_q.size() > 0) && !out_ready;
        e   = '{in_wreg_en, in_wmem_en, in_ops, in_wreg};
        @(posedge clk);
        if (!reset) begin
            m_q.delete();
            m_stall = 0;
        end else begin
            if (stl && m_stall < 16'hFFFF) m_stall++;
            if (flush) begin
                m_q.delete();
            end else begin
                if (xf) void'(m_q.pop_front());
                if (acc) m_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [127:0] ops);
        in_valid   = v;
        in_ops     = ops;
        in_wreg_en = 1'($urandom);
        in_wmem_en = 1'($urandom);
        in_wreg    = 3'($urandom);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        logic [127:0] p;
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, rnd128());
        step(); step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_ops !== 128'd0) begin n_fail++; $display("FAIL reset_out_ops: got %h want 0", out_ops); end
        n_checks++; if (out_wreg !== 3'd0 || out_wreg_en !== 1'b0 || out_wmem_en !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got wreg %h en %b%b want 0 00", out_wreg, out_wreg_en, out_wmem_en); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        reset = 1'b1;
        p = rnd128();
        drive(1'b1, p);
        step();
        n_checks++; if (out_valid !== 1'b1 || out_ops !== p) begin n_fail++; $display("FAIL reset_first_accept: got v=%b %h want v=1 %h", out_valid, out_ops, p); end
        drive(1'b0, '0);
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [127:0] p;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            p = {64'(2*k+2), 64'(2*k+1)};
            drive(1'b1, p);
            step();
            n_checks++; if (out_valid !== 1'b1 || out_ops !== p) begin n_fail++; $display("FAIL stream_data%0d: got v=%b %h want %h", k, out_valid, out_ops, p); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready%0d: got %b want 1", k, in_ready); end
        end
        drive(1'b0, '0);
        step();
        n_checks++; if (stall_cnt !== 16'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end: got stall %0d v=%b want 0 0", stall_cnt, out_valid); end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b;
        int unsigned  s0;
        a = rnd128(); b = rnd128();
        s0 = m_stall;
        out_ready = 1'b0;
        drive(1'b1, a); step();
        drive(1'b1, b); step();
        n_checks++; if (out_ops !== a || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %h rdy=%b want %h rdy=0", out_ops, in_ready, a); end
        drive(1'b0, '0);
        step(); step();
        n_checks++; if (32'(stall_cnt) !== s0 + 3) begin n_fail++; $display("FAIL bp_stall: got %0d want %0d", stall_cnt, s0 + 3); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b1 || out_ops !== b) begin n_fail++; $display("FAIL bp_second: got v=%b %h want %h", out_valid, out_ops, b); end
        step();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_empty: got v=%b rdy=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_flush();
        logic [127:0] c;
        out_ready = 1'b0;
        drive(1'b1, rnd128()); step();
        drive(1'b1, rnd128()); step();
        c = rnd128();
        drive(1'b1, c); in_wreg_en = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0);
        n_checks++; if (out_valid !== 1'b0 || out_wreg_en !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_clear: got v=%b wen=%b rdy=%b want 0 0 1", out_valid, out_wreg_en, in_ready); end
        n_checks++; if (32'(stall_cnt) !== m_stall || stall_cnt === 16'd0) begin n_fail++; $display("FAIL flush_stall: got %0d want %0d", stall_cnt, m_stall); end
        out_ready = 1'b1;
        step(); step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got v=%b ops %h want 0", out_valid, out_ops); end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), rnd128());
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
            n_checks++;
            if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2) || 32'(stall_cnt) !== m_stall ||
                (m_q.size() > 0 && (out_ops !== m_q[0].ops || out_wreg !== m_q[0].wreg ||
                 out_wreg_en !== m_q[0].wreg_en || out_wmem_en !== m_q[0].wmem_en)) ||
                (m_q.size() == 0 && (out_wreg_en !== 1'b0 || out_wmem_en !== 1'b0))) begin
                n_fail++;
                if (errs < 5) $display("FAIL random_cycle%0d: got v=%b rdy=%b stall=%0d ops=%h want v=%b rdy=%b stall=%0d ops=%h",
                    i, out_valid, in_ready, stall_cnt, out_ops, m_q.size() > 0, m_q.size() < 2, m_stall,
                    (m_q.size() > 0) ? m_q[0].ops : 128'd0);
                errs++;
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive(1'b1, rnd128()); step();
        drive(1'b1, rnd128()); step();
        reset = 1'b0; flush = 1'b1;
        step();
        reset = 1'b1; flush = 1'b0;
        drive(1'b0, '0);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'd0 || out_ops !== 128'd0) begin n_fail++; $display("FAIL midreset: got v=%b rdy=%b stall=%0d ops=%h want 0 1 0 0", out_valid, in_ready, stall_cnt, out_ops); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp;
        b_reset = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_wreg_en = 1'b0; b_in_wmem_en = 1'b0; b_in_ops = '0; b_in_wreg = '0;
        tick(); tick();
        b_reset = 1'b1;
        b_in_valid = 1'b1; b_in_ops = {$urandom, $urandom, $urandom};
        tick();
        b_in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = (k > 15) ? 4'd15 : 4'(k);
            n_checks++; if (b_stall_cnt !== exp) begin n_fail++; $display("FAIL sat_cycle%0d: got %0d want %0d", k, b_stall_cnt, exp); end
        end
    endtask

    task automatic test_param();
        logic [95:0] p;
        logic [31:0] dead;
        b_out_ready = 1'b1;
        tick();
        p = {32'hDEADBEEF, $urandom, $urandom};
        b_in_valid = 1'b1; b_in_ops = p; b_in_wreg = 3'd5; b_in_wmem_en = 1'b1;
        tick();
        b_in_valid = 1'b0;
        dead = b_out_ops[95:64];
        n_checks++; if (b_out_valid !== 1'b1 || dead !== 32'hDEADBEEF) begin n_fail++; $display("FAIL param_op2: got v=%b %h want DEADBEEF", b_out_valid, dead); end
        n_checks++; if (b_out_ops !== p || b_out_wreg !== 3'd5 || b_out_wmem_en !== 1'b1) begin n_fail++; $display("FAIL param_payload: got %h wreg %0d want %h 5", b_out_ops, b_out_wreg, p); end
        n_checks++; if (b_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL param_stall_held: got %0d want 15", b_stall_cnt); end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0);
        b_reset = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_wreg_en = 1'b0; b_in_wmem_en = 1'b0; b_in_ops = '0; b_in_wreg = '0;
        m_stall = 0;
        #2;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_random();
        test_mid_reset();
        test_saturation();
        test_param();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline register for inter-stage boundaries (first use: execute->mem).
- Carries write-enable controls, N operand words and a destination register address.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure is absorbed without a combinational ready path.
- Adds flush (bubble insertion) and a saturating stall counter for performance debug.

Parameters:
- DATA_WIDTH, 64, width of one operand word.
- NUM_OPS, 2, number of operand words carried.
- REG_ADDR_WIDTH, 3, destination register address width.
- STALL_CNT_WIDTH, 16, width of stall counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low (0 = reset).
- flush  input  1  discard all held and incoming entries this cycle.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept; registered.
- in_wreg_en  input  1  register-write enable.
- in_wmem_en  input  1  memory-write enable.
- in_ops  input  NUM_OPS*DATA_WIDTH  operands, op k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_wreg  input  REG_ADDR_WIDTH  destination register.
- out_valid  output  1  downstream entry valid.
- out_ready  input  1  downstream accepts.
- out_wreg_en  output  1  gated by out_valid.
- out_wmem_en  output  1  gated by out_valid.
- out_ops  output  NUM_OPS*DATA_WIDTH  operands.
- out_wreg  output  REG_ADDR_WIDTH  destination register.
- stall_cnt  output  STALL_CNT_WIDTH  saturating count of out_valid && !out_ready cycles.

Behaviour:
- Storage: main entry (drives outputs) plus skid entry; each entry has a valid bit.
- Handshake: accept when in_valid && in_ready; transfer out when out_valid && out_ready.
- in_ready = !skid_valid, held in a flop; no combinational path from out_ready to in_ready.
- Latency: an accepted entry appears at the outputs on the next rising edge if main is empty or draining that cycle; otherwise it goes to skid.
- States, by {main_valid, skid_valid}: EMPTY (0,0), ONE (1,0), FULL (1,1).
- EMPTY: accept -> ONE.
- ONE:
  - accept and transfer -> ONE, main loads the new entry;
  - accept, no transfer -> FULL, new entry goes to skid;
  - transfer only -> EMPTY;
  - neither -> hold.
- FULL: in_ready = 0. Transfer -> ONE, skid moves to main and skid_valid clears. No transfer -> hold, all fields stable.
- Ordering: strict FIFO; skid is always older than any new input.
- out_wreg_en = main_wreg_en & main_valid; out_wmem_en = main_wmem_en & main_valid.
- out_ops and out_wreg are don't-care when out_valid = 0, but hold their last value (no X).
- Flush (reset high, flush high): next edge clears both valid bits and any same-cycle accept is dropped. in_ready = 1 the following cycle. Data fields are not cleared. Flush has priority over every handshake event.
- Reset (reset low at an edge): all valid bits 0, all data fields 0, in_ready = 1, stall_cnt = 0.
  - Outputs after reset: out_valid 0, out_wreg_en 0, out_wmem_en 0, out_ops 0, out_wreg 0, in_ready 1, stall_cnt 0.
  - Mid-operation reset discards held entries identically; reset has priority over flush.
- stall_cnt: increments each cycle with out_valid && !out_ready; saturates at all-ones (no wrap); cleared only by reset, not by flush.

Decomposition:
- Shared package (pipe_pkg): DATAPATH_WIDTH, REGFILE_ADDR, and a packed stage-payload typedef {wreg_en, wmem_en, ops, wreg}.
- Natural sub-module: pipe_skid_entry — one payload register plus valid bit with load/clear controls, instantiated twice.
- Counter stays inline.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ops=0, in_ready=1, stall_cnt=0; first accept after release appears at the outputs one cycle later.
- Streaming: out_ready=1, send ops {0x1,0x2},{0x3,0x4},{0x5,0x6} on consecutive cycles -> same order out, one-cycle latency, in_ready constantly 1, stall_cnt=0.
- Backpressure: out_ready=0 while sending A then B -> A on outputs, in_ready=0 after B; raise out_ready -> A then B out, no loss or duplication, stall_cnt equals the stalled-cycle count.
- Flush in FULL with in_valid=1, in_wreg_en=1 -> next cycle out_valid=0, out_wreg_en=0, in_ready=1; the dropped input never appears; stall_cnt unchanged.
- Saturation: STALL_CNT_WIDTH=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Parametrisation: NUM_OPS=3, DATA_WIDTH=32, send op2=0xDEADBEEF -> appears at out_ops[95:64].
